// File: rtl/video_pattern_scheduler_if.sv
// Pattern-scheduler bus: frame/request inputs from the video controller and
// the registered pattern-select outputs that feed the frame generator.
interface video_pattern_scheduler_if #(
  parameter int SEL_BITS = 3,
  parameter int CNT_BITS = 8
);
  logic                frame_start;
  logic                adv_req;
  logic                pause;
  logic                sel_req;
  logic [SEL_BITS-1:0] sel_val;
  logic [SEL_BITS-1:0] pattern_sel;
  logic                pattern_change;
  logic [CNT_BITS-1:0] dwell_cnt;
  logic                pending;

  modport master (
    output frame_start, adv_req, pause, sel_req, sel_val,
    input  pattern_sel, pattern_change, dwell_cnt, pending
  );

  modport slave (
    input  frame_start, adv_req, pause, sel_req, sel_val,
    output pattern_sel, pattern_change, dwell_cnt, pending
  );
endinterface

// File: rtl/video_pattern_scheduler.sv
// Frame-synchronous test-pattern scheduler: auto-cycles patterns with a dwell
// count, and applies manual advance / direct select only at frame_start.
module video_pattern_scheduler #(
  parameter int NUM_PATTERNS = 8,
  parameter int SEL_BITS     = 3,
  parameter int DWELL_FRAMES = 120,
  parameter int CNT_BITS     = 8
) (
  input  logic                     video_clk_pix,
  input  logic                     video_rst,
  video_pattern_scheduler_if.slave sched
);

  // state     | meaning
  // ST_RUN    | auto-advance active, dwell counter counts frames
  // ST_PAUSED | auto-advance suspended, dwell counter held
  typedef enum logic {ST_RUN, ST_PAUSED} mode_t;

  localparam logic [SEL_BITS:0]   NUM_P      = NUM_PATTERNS[SEL_BITS:0];
  localparam logic [SEL_BITS-1:0] LAST_IDX   = SEL_BITS'(NUM_PATTERNS - 1);
  localparam logic [CNT_BITS-1:0] DWELL_LAST = CNT_BITS'(DWELL_FRAMES - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX    = '1;

  mode_t               mode_q, mode_nxt;
  logic                adv_pend_q, adv_pend_nxt;
  logic                sel_pend_q, sel_pend_nxt;
  logic [SEL_BITS-1:0] sel_store_q, sel_store_nxt;
  logic [SEL_BITS-1:0] pat_q, pat_nxt;
  logic [CNT_BITS-1:0] cnt_q, cnt_nxt;
  logic                chg_q, chg_nxt;

  logic                sel_now;
  logic                take;
  logic [SEL_BITS-1:0] next_idx;
  logic [SEL_BITS-1:0] target;

  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      mode_q      <= ST_RUN;
      adv_pend_q  <= 1'b0;
      sel_pend_q  <= 1'b0;
      sel_store_q <= '0;
      pat_q       <= '0;
      cnt_q       <= '0;
      chg_q       <= 1'b0;
    end else begin
      mode_q      <= mode_nxt;
      adv_pend_q  <= adv_pend_nxt;
      sel_pend_q  <= sel_pend_nxt;
      sel_store_q <= sel_store_nxt;
      pat_q       <= pat_nxt;
      cnt_q       <= cnt_nxt;
      chg_q       <= chg_nxt;
    end
  end

  always_comb begin
    mode_nxt      = mode_q;
    sel_now       = sched.sel_req && ({1'b0, sched.sel_val} < NUM_P);
    adv_pend_nxt  = adv_pend_q | sched.adv_req;
    sel_pend_nxt  = sel_pend_q | sel_now;
    sel_store_nxt = sel_now ? sched.sel_val : sel_store_q;
    next_idx      = (pat_q == LAST_IDX) ? '0 : pat_q + 1'b1;
    target        = pat_q;
    take          = 1'b0;
    pat_nxt       = pat_q;
    cnt_nxt       = cnt_q;
    chg_nxt       = 1'b0;

    case (mode_q)
      ST_RUN:    if (sched.pause)  mode_nxt = ST_PAUSED;
      ST_PAUSED: if (!sched.pause) mode_nxt = ST_RUN;
      default:   mode_nxt = ST_RUN;
    endcase

    // Mode used here is the registered one, so a pause change lands on the
    // frame_start after it was sampled.
    if (sched.frame_start) begin
      adv_pend_nxt = 1'b0;
      sel_pend_nxt = 1'b0;
      if (sel_pend_q || sel_now) begin
        target = sel_store_nxt;
        take   = 1'b1;
      end else if (adv_pend_q || sched.adv_req ||
                   (mode_q == ST_RUN && cnt_q == DWELL_LAST)) begin
        target = next_idx;
        take   = 1'b1;
      end
      if (take) begin
        pat_nxt = target;
        cnt_nxt = '0;
        chg_nxt = (target != pat_q);
      end else if (mode_q == ST_RUN && cnt_q != CNT_MAX) begin
        cnt_nxt = cnt_q + 1'b1;
      end
    end
  end

  assign sched.pattern_sel    = pat_q;
  assign sched.pattern_change = chg_q;
  assign sched.dwell_cnt      = cnt_q;
  assign sched.pending        = adv_pend_q | sel_pend_q;

endmodule

// File: doc/video_pattern_scheduler.md
# video_pattern_scheduler

Frame-synchronous scheduler that selects which test pattern the video source renders. It auto-cycles through `NUM_PATTERNS` patterns, dwelling `DWELL_FRAMES` frames on each. It also accepts manual-advance, pause and direct-select requests. All pattern changes are committed only at `frame_start`, so a frame is never split between two patterns. It sits in the pixel-clock domain beside the frame generator, whose pattern-select input it drives.

## Interface

Parameters:
- `NUM_PATTERNS`, 8: number of selectable patterns (≥2).
- `SEL_BITS`, 3: width of pattern select; 2^SEL_BITS ≥ NUM_PATTERNS.
- `DWELL_FRAMES`, 120: frames per pattern in auto mode (≥1).
- `CNT_BITS`, 8: dwell counter width; 2^CNT_BITS > DWELL_FRAMES.

Ports:
- `video_clk_pix` in 1: pixel clock. This is the only clock.
- `video_rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: single-cycle pulse at the start of each frame.
- `adv_req` in 1: single-cycle pulse requesting the next pattern.
- `pause` in 1: level. While high, auto-advance is suspended.
- `sel_req` in 1: single-cycle pulse requesting a jump to `sel_val`.
- `sel_val` in SEL_BITS: target pattern for `sel_req`.
- `pattern_sel` out SEL_BITS: current pattern index, registered.
- `pattern_change` out 1: one-cycle pulse in the cycle `pattern_sel` takes a new value.
- `dwell_cnt` out CNT_BITS: frames elapsed on the current pattern.
- `pending` out 1: high while an advance or select request is latched and awaiting `frame_start`.

## Operation

- Mode FSM has two states, RUN and PAUSED.
  - RUN→PAUSED when `pause`=1. PAUSED→RUN when `pause`=0.
  - The state is sampled every cycle. The state change takes effect at the next `frame_start`.
- Request latches:
  - `adv_req` sets `adv_pend`. Multiple pulses before one `frame_start` collapse into a single advance.
  - `sel_req` with `sel_val` < NUM_PATTERNS sets `sel_pend` and stores `sel_val`. A later `sel_req` overwrites the stored value (last wins).
  - `sel_req` with `sel_val` ≥ NUM_PATTERNS is ignored: no latch and no other effect.
  - `pending` = `adv_pend` | `sel_pend`.
- At each `frame_start`, the first matching rule applies:
  1. `sel_pend`, or `sel_req` valid in the same cycle: `pattern_sel` ← stored/new `sel_val`.
  2. `adv_pend`, or `adv_req` in the same cycle: `pattern_sel` ← next index.
  3. RUN and `dwell_cnt` = DWELL_FRAMES−1: `pattern_sel` ← next index.
  4. Otherwise: `pattern_sel` is held.
- Next index: `pattern_sel`+1, wrapping from NUM_PATTERNS−1 to 0.
- After any `frame_start` that applies rule 1–3:
  - Both latches clear.
  - `dwell_cnt` ← 0.
  - `pattern_change` pulses, but only if the new value differs from the old. Selecting the current pattern clears latches and resets `dwell_cnt` with no pulse.
- After a rule-4 `frame_start`:
  - RUN: `dwell_cnt` increments.
  - PAUSED: `dwell_cnt` is held.
  - `dwell_cnt` saturates at 2^CNT_BITS−1.
- Manual advance and select work in both RUN and PAUSED.
- A rule-3 advance combined with a valid `sel_req` performs only the select.

## Timing

- Reset values: `pattern_sel`=0, `pattern_change`=0, `dwell_cnt`=0, `pending`=0; FSM in RUN; latches clear.
- Reset mid-frame discards pending requests. The first post-reset `frame_start` counts as a normal frame.
- `frame_start` sampled high in cycle N gives updated `pattern_sel`, `dwell_cnt` and `pattern_change` in cycle N+1. Latency is 1 cycle.
- `pending` rises the cycle after the request pulse and falls the cycle after the consuming `frame_start`.
- A request coinciding with `frame_start` is consumed by that `frame_start`. `pending` does not rise.
- A request arriving in cycle N+1, right after `frame_start`, waits for the following frame.
- No combinational path from inputs to outputs.

## Test plan

- Auto cycling:
  - Stimulus: reset, DWELL_FRAMES=3, NUM_PATTERNS=4, 14 `frame_start` pulses spaced 20 cycles apart.
  - Required: `pattern_sel` steps 0→1→2→3→0 after frames 3, 6, 9, 12.
  - Required: `pattern_change` pulses exactly 4 times, each 1 cycle after the triggering `frame_start`.
- Manual advance collapse:
  - Stimulus: 3 `adv_req` pulses mid-frame with `pattern_sel`=1.
  - Required: `pending`=1 until the next `frame_start`; `pattern_sel`=2 (not 4); `dwell_cnt`=0.
- Pause:
  - Stimulus: `pause`=1 at `dwell_cnt`=1, then 10 frames.
  - Required: `pattern_sel` and `dwell_cnt` are unchanged.
  - Stimulus: `adv_req` during pause. Required: `pattern_sel` increments.
  - Stimulus: release `pause`. Required: auto-advance resumes after DWELL_FRAMES more frames.
- Select priority and validity:
  - Stimulus: `sel_req` `sel_val`=5 with NUM_PATTERNS=4. Required: ignored, `pending`=0.
  - Stimulus: `adv_req`, then `sel_req` `sel_val`=3, then `sel_req` `sel_val`=2, then `frame_start`. Required: `pattern_sel`=2.
  - Stimulus: select the current pattern. Required: no `pattern_change` pulse; `dwell_cnt`=0.
- Simultaneous events:
  - Stimulus: `adv_req` asserted in the same cycle as the dwell-expiry `frame_start`. Required: a single advance (+1); `pending` never rises.
- Reset mid-operation:
  - Stimulus: latch `sel_req` `sel_val`=2 at `pattern_sel`=3, assert `video_rst` for 1 cycle, then `frame_start`.
  - Required: `pattern_sel`=0, `pending`=0, `dwell_cnt`=1.
